// File: rtl/color_mixer_arbiter.sv
// Two requesters share one 2-stage colour mixer through round-robin arbitration.
// Per-requester result FIFOs plus credit accounting ensure that no result is ever dropped.
module color_mixer_arbiter #(
  parameter int SUB_PIXEL_WIDTH     = 8,
  parameter int NUMBER_OF_SUB_PIXEL = 4,
  parameter int TAG_WIDTH           = 8,
  parameter int FIFO_DEPTH          = 4,
  localparam int PIXEL_WIDTH        = SUB_PIXEL_WIDTH * NUMBER_OF_SUB_PIXEL
) (
  input  logic                   aclk,
  input  logic                   reset,
  input  logic                   s0_valid,
  output logic                   s0_ready,
  input  logic [PIXEL_WIDTH-1:0] s0_color_a,
  input  logic [PIXEL_WIDTH-1:0] s0_color_b,
  input  logic [PIXEL_WIDTH-1:0] s0_color_c,
  input  logic [PIXEL_WIDTH-1:0] s0_color_d,
  input  logic [TAG_WIDTH-1:0]   s0_tag,
  input  logic                   s1_valid,
  output logic                   s1_ready,
  input  logic [PIXEL_WIDTH-1:0] s1_color_a,
  input  logic [PIXEL_WIDTH-1:0] s1_color_b,
  input  logic [PIXEL_WIDTH-1:0] s1_color_c,
  input  logic [PIXEL_WIDTH-1:0] s1_color_d,
  input  logic [TAG_WIDTH-1:0]   s1_tag,
  output logic                   m0_valid,
  input  logic                   m0_ready,
  output logic [PIXEL_WIDTH-1:0] m0_color,
  output logic [TAG_WIDTH-1:0]   m0_tag,
  output logic                   m1_valid,
  input  logic                   m1_ready,
  output logic [PIXEL_WIDTH-1:0] m1_color,
  output logic [TAG_WIDTH-1:0]   m1_tag,
  output logic                   busy
);

  localparam int W   = SUB_PIXEL_WIDTH;
  localparam int W2  = 2 * SUB_PIXEL_WIDTH;
  localparam int PW  = PIXEL_WIDTH;
  localparam int NSP = NUMBER_OF_SUB_PIXEL;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int EW  = PW + TAG_WIDTH;
  localparam logic [CW:0]   DEPTH_OCC = FIFO_DEPTH[CW:0];
  localparam logic [W2:0]   ROUND     = {{(W + 1){1'b0}}, {W{1'b1}}};

  typedef enum logic {RR_S0 = 1'b0, RR_S1 = 1'b1} rr_t;
  rr_t rr_q, rr_d;

  logic [CW-1:0] count_q    [2];
  logic [CW-1:0] inflight_q [2];
  logic [AW-1:0] wptr_q     [2];
  logic [AW-1:0] rptr_q     [2];
  logic [EW-1:0] mem_q      [2][FIFO_DEPTH];
  logic [CW:0]   occ        [2];
  logic [EW-1:0] head       [2];

  logic [1:0] elig, grant, push, pop, empty, m_ready;

  logic          issue;
  logic [PW-1:0] op_a, op_b, op_c, op_d;
  logic [TAG_WIDTH-1:0] op_tag;

  logic                 v1_q, id1_q;
  logic [TAG_WIDTH-1:0] tag1_q;
  logic [W2-1:0]        pab_q [NSP];
  logic [W2-1:0]        pcd_q [NSP];

  logic [W2:0]          acc [NSP];
  logic [PW-1:0]        mixed;

  logic                 v2_q, id2_q;
  logic [TAG_WIDTH-1:0] tag2_q;
  logic [PW-1:0]        res2_q;

  // Occupancy counts both buffered and in-flight results, so a grant always owns a FIFO slot.
  always_comb begin
    for (int unsigned i = 0; i < 2; i++) begin
      occ[i]   = {1'b0, count_q[i]} + {1'b0, inflight_q[i]};
      empty[i] = (count_q[i] == '0);
    end
    elig[0] = s0_valid && (occ[0] < DEPTH_OCC);
    elig[1] = s1_valid && (occ[1] < DEPTH_OCC);
  end

  always_comb begin
    grant = '0;
    rr_d  = rr_q;
    if (!reset) begin
      if (elig == 2'b11) begin
        grant = (rr_q == RR_S0) ? 2'b01 : 2'b10;
        rr_d  = (rr_q == RR_S0) ? RR_S1 : RR_S0;
      end else if (elig[0]) begin
        grant = 2'b01;
        rr_d  = RR_S1;
      end else if (elig[1]) begin
        grant = 2'b10;
        rr_d  = RR_S0;
      end
    end
  end

  assign s0_ready = grant[0];
  assign s1_ready = grant[1];
  assign issue    = |grant;
  assign op_a     = grant[1] ? s1_color_a : s0_color_a;
  assign op_b     = grant[1] ? s1_color_b : s0_color_b;
  assign op_c     = grant[1] ? s1_color_c : s0_color_c;
  assign op_d     = grant[1] ? s1_color_d : s0_color_d;
  assign op_tag   = grant[1] ? s1_tag     : s0_tag;

  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
    end else begin
      v1_q <= issue;
      v2_q <= v1_q;
    end
  end

  always_ff @(posedge aclk) begin
    if (issue) begin
      id1_q  <= grant[1];
      tag1_q <= op_tag;
      for (int unsigned k = 0; k < NSP; k++) begin
        pab_q[k] <= W2'(op_a[k*W +: W]) * W2'(op_b[k*W +: W]);
        pcd_q[k] <= W2'(op_c[k*W +: W]) * W2'(op_d[k*W +: W]);
      end
    end
  end

  // The rounded sum fits in 2W+1 bits; its top bit set means the shifted value exceeds 2^W-1.
  always_comb begin
    mixed = '0;
    for (int unsigned k = 0; k < NSP; k++) begin
      acc[k] = {1'b0, pab_q[k]} + {1'b0, pcd_q[k]} + ROUND;
      mixed[k*W +: W] = acc[k][W2] ? {W{1'b1}} : acc[k][W2-1:W];
    end
  end

  always_ff @(posedge aclk) begin
    if (v1_q) begin
      id2_q  <= id1_q;
      tag2_q <= tag1_q;
      res2_q <= mixed;
    end
  end

  assign push    = v2_q ? (id2_q ? 2'b10 : 2'b01) : 2'b00;
  assign m_ready = {m1_ready, m0_ready};
  assign pop     = ~empty & m_ready;

  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      rr_q <= RR_S0;
      for (int unsigned i = 0; i < 2; i++) begin
        count_q[i]    <= '0;
        inflight_q[i] <= '0;
        wptr_q[i]     <= '0;
        rptr_q[i]     <= '0;
      end
    end else begin
      rr_q <= rr_d;
      for (int unsigned i = 0; i < 2; i++) begin
        if (push[i]) wptr_q[i] <= wptr_q[i] + 1'b1;
        if (pop[i])  rptr_q[i] <= rptr_q[i] + 1'b1;
        if (push[i] && !pop[i])      count_q[i] <= count_q[i] + 1'b1;
        else if (!push[i] && pop[i]) count_q[i] <= count_q[i] - 1'b1;
        if (grant[i] && !push[i])      inflight_q[i] <= inflight_q[i] + 1'b1;
        else if (!grant[i] && push[i]) inflight_q[i] <= inflight_q[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge aclk) begin
    for (int unsigned i = 0; i < 2; i++) begin
      if (push[i]) mem_q[i][wptr_q[i]] <= {res2_q, tag2_q};
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < 2; i++) begin
      head[i] = empty[i] ? '0 : mem_q[i][rptr_q[i]];
    end
  end

  assign m0_valid = ~empty[0];
  assign m1_valid = ~empty[1];
  assign m0_color = head[0][EW-1:TAG_WIDTH];
  assign m0_tag   = head[0][TAG_WIDTH-1:0];
  assign m1_color = head[1][EW-1:TAG_WIDTH];
  assign m1_tag   = head[1][TAG_WIDTH-1:0];
  assign busy     = ~&empty | (inflight_q[0] != '0) | (inflight_q[1] != '0);

endmodule

// File: tb/tb_color_mixer_arbiter.sv
// Randomised bench for color_mixer_arbiter: a queue-based reference predicts grants,
// credit limits and per-requester results; scenario tasks check directed corner cases.
module tb_color_mixer_arbiter;

  localparam int W  = 8;
  localparam int PW = 32;
  localparam int TW = 8;
  localparam int D  = 4;

  logic          aclk  = 1'b0;
  logic          reset = 1'b1;
  logic          s0_valid = 1'b0, s1_valid = 1'b0;
  logic          s0_ready, s1_ready;
  logic [PW-1:0] s0_color_a = '0, s0_color_b = '0, s0_color_c = '0, s0_color_d = '0;
  logic [PW-1:0] s1_color_a = '0, s1_color_b = '0, s1_color_c = '0, s1_color_d = '0;
  logic [TW-1:0] s0_tag = '0, s1_tag = '0;
  logic          m0_valid, m1_valid;
  logic          m0_ready = 1'b0, m1_ready = 1'b0;
  logic [PW-1:0] m0_color, m1_color;
  logic [TW-1:0] m0_tag, m1_tag;
  logic          busy;

  int unsigned tests_run = 0;
  int unsigned failures  = 0;

  logic [PW+TW-1:0] expq0[$];
  logic [PW+TW-1:0] expq1[$];
  int unsigned out0 = 0, out1 = 0;
  int          rr_m = 0;
  int          ghist[$];

  color_mixer_arbiter #(
    .SUB_PIXEL_WIDTH(W),
    .NUMBER_OF_SUB_PIXEL(4),
    .TAG_WIDTH(TW),
    .FIFO_DEPTH(D)
  ) dut (
    .aclk(aclk), .reset(reset),
    .s0_valid(s0_valid), .s0_ready(s0_ready),
    .s0_color_a(s0_color_a), .s0_color_b(s0_color_b),
    .s0_color_c(s0_color_c), .s0_color_d(s0_color_d), .s0_tag(s0_tag),
    .s1_valid(s1_valid), .s1_ready(s1_ready),
    .s1_color_a(s1_color_a), .s1_color_b(s1_color_b),
    .s1_color_c(s1_color_c), .s1_color_d(s1_color_d), .s1_tag(s1_tag),
    .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_color(m0_color), .m0_tag(m0_tag),
    .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_color(m1_color), .m1_tag(m1_tag),
    .busy(busy)
  );

  always #5 aclk = ~aclk;

  function automatic logic [PW-1:0] mix(input logic [PW-1:0] a, input logic [PW-1:0] b,
                                        input logic [PW-1:0] c, input logic [PW-1:0] d);
    logic [PW-1:0] r;
    int unsigned s;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      s = int'(a[k*W +: W]) * int'(b[k*W +: W]) + int'(c[k*W +: W]) * int'(d[k*W +: W]);
      s = (s + 255) / 256;
      s = (s > 255) ? 255 : s;
      r[k*W +: W] = s[7:0];
    end
    return r;
  endfunction

  function automatic logic [PW-1:0] rnd_px();
    return ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
  endfunction

  // Reference: outstanding = accepted - popped; a requester may be granted while outstanding < D.
  always @(negedge aclk) begin
    logic e0, e1, g0, g1;
    if (reset) begin
      expq0.delete();
      expq1.delete();
      out0 = 0;
      out1 = 0;
      rr_m = 0;
    end else begin
      e0 = s0_valid && (out0 < D);
      e1 = s1_valid && (out1 < D);
      g0 = e0 && (!e1 || rr_m == 0);
      g1 = e1 && !g0;
      tests_run++;
      if ({s1_ready, s0_ready} !== {g1, g0}) begin
        failures++;
        $display("FAIL grant: ready(s1,s0)=%b expected %b at %0t", {s1_ready, s0_ready}, {g1, g0}, $time);
      end
      tests_run++;
      if (busy !== ((out0 + out1) != 0)) begin
        failures++;
        $display("FAIL busy: got %b expected %b at %0t", busy, ((out0 + out1) != 0), $time);
      end
      tests_run++;
      if ((dut.push[0] && int'(dut.count_q[0]) == D && !(m0_valid && m0_ready)) ||
          (dut.push[1] && int'(dut.count_q[1]) == D && !(m1_valid && m1_ready))) begin
        failures++;
        $display("FAIL fifo_overflow: push into full FIFO at %0t", $time);
      end
      if (m0_valid === 1'b1 && m0_ready) begin
        tests_run++;
        if (expq0.size() == 0) begin
          failures++;
          $display("FAIL m0_result: got %h/%h expected no result at %0t", m0_color, m0_tag, $time);
        end else begin
          if ({m0_color, m0_tag} !== expq0[0]) begin
            failures++;
            $display("FAIL m0_result: got %h/%h expected %h/%h at %0t", m0_color, m0_tag,
                     expq0[0][PW+TW-1:TW], expq0[0][TW-1:0], $time);
          end
          void'(expq0.pop_front());
          out0--;
        end
      end
      if (m1_valid === 1'b1 && m1_ready) begin
        tests_run++;
        if (expq1.size() == 0) begin
          failures++;
          $display("FAIL m1_result: got %h/%h expected no result at %0t", m1_color, m1_tag, $time);
        end else begin
          if ({m1_color, m1_tag} !== expq1[0]) begin
            failures++;
            $display("FAIL m1_result: got %h/%h expected %h/%h at %0t", m1_color, m1_tag,
                     expq1[0][PW+TW-1:TW], expq1[0][TW-1:0], $time);
          end
          void'(expq1.pop_front());
          out1--;
        end
      end
      if (g0) begin
        expq0.push_back({mix(s0_color_a, s0_color_b, s0_color_c, s0_color_d), s0_tag});
        out0++;
        ghist.push_back(0);
        rr_m = 1;
      end else if (g1) begin
        expq1.push_back({mix(s1_color_a, s1_color_b, s1_color_c, s1_color_d), s1_tag});
        out1++;
        ghist.push_back(1);
        rr_m = 0;
      end
    end
  end

  // One clock of stimulus; an offered but not yet accepted operation is held unchanged.
  task automatic step(input bit v0, input bit v1, input bit r0, input bit r1);
    bit hold0, hold1;
    @(negedge aclk);
    hold0 = s0_valid && !s0_ready;
    hold1 = s1_valid && !s1_ready;
    @(posedge aclk);
    #1;
    if (!hold0) begin
      s0_color_a = rnd_px(); s0_color_b = rnd_px(); s0_color_c = rnd_px(); s0_color_d = rnd_px();
      s0_tag = 8'($urandom);
    end
    if (!hold1) begin
      s1_color_a = rnd_px(); s1_color_b = rnd_px(); s1_color_c = rnd_px(); s1_color_d = rnd_px();
      s1_tag = 8'($urandom);
    end
    s0_valid = v0 || hold0;
    s1_valid = v1 || hold1;
    m0_ready = r0;
    m1_ready = r1;
  endtask

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      if (!busy && !s0_valid && !s1_valid) break;
      step(0, 0, 1, 1);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    s0_valid = 1'b1;
    s1_valid = 1'b1;
    m0_ready = 1'b1;
    m1_ready = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    tests_run++;
    if ({s0_ready, s1_ready, m0_valid, m1_valid, busy} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl: s0r,s1r,m0v,m1v,busy=%b expected 00000", {s0_ready, s1_ready, m0_valid, m1_valid, busy});
    end
    tests_run++;
    if ({m0_color, m0_tag, m1_color, m1_tag} !== '0) begin
      failures++;
      $display("FAIL reset_data: m0=%h/%h m1=%h/%h expected zero", m0_color, m0_tag, m1_color, m1_tag);
    end
    s0_valid = 1'b0;
    s1_valid = 1'b0;
    reset = 1'b0;
    repeat (3) step(0, 0, 1, 1);
    tests_run++;
    if ({busy, m0_valid, m1_valid} !== 3'b000) begin
      failures++;
      $display("FAIL post_reset_idle: busy,m0v,m1v=%b expected 000", {busy, m0_valid, m1_valid});
    end
  endtask

  task automatic test_single();
    @(posedge aclk);
    #1;
    s0_color_a = 32'hFFFF_FFFF; s0_color_b = 32'h8080_8080; s0_color_c = '0; s0_color_d = '0;
    s0_tag = 8'h5A; s0_valid = 1'b1; s1_valid = 1'b0; m0_ready = 1'b1;
    #1;
    tests_run++;
    if (s0_ready !== 1'b1) begin
      failures++;
      $display("FAIL single_ready: s0_ready=%b expected 1", s0_ready);
    end
    for (int c = 1; c <= 3; c++) begin
      @(posedge aclk);
      #1;
      s0_valid = 1'b0;
      tests_run++;
      if (c < 3 && m0_valid !== 1'b0) begin
        failures++;
        $display("FAIL single_latency: m0_valid=%b at cycle +%0d expected 0", m0_valid, c);
      end else if (c == 3 && {m0_valid, m0_color, m0_tag} !== {1'b1, 32'h8080_8080, 8'h5A}) begin
        failures++;
        $display("FAIL single_result: v=%b color=%h tag=%h expected 1/80808080/5a", m0_valid, m0_color, m0_tag);
      end
    end
  endtask

  task automatic test_saturation();
    int waited;
    drain();
    @(posedge aclk);
    #1;
    s0_color_a = '1; s0_color_b = '1; s0_color_c = '1; s0_color_d = '1;
    s0_tag = 8'hC3; s0_valid = 1'b1; m0_ready = 1'b1;
    @(posedge aclk);
    #1;
    s0_color_a = '0; s0_color_b = '0; s0_color_c = '0; s0_color_d = '0; s0_tag = 8'h3C;
    @(posedge aclk);
    #1;
    s0_valid = 1'b0;
    waited = 0;
    while (m0_valid !== 1'b1 && waited < 10) begin
      @(posedge aclk);
      #1;
      waited++;
    end
    tests_run++;
    if ({m0_valid, m0_color, m0_tag} !== {1'b1, 32'hFFFF_FFFF, 8'hC3}) begin
      failures++;
      $display("FAIL saturate_max: v=%b color=%h tag=%h expected 1/ffffffff/c3", m0_valid, m0_color, m0_tag);
    end
    @(posedge aclk);
    #1;
    tests_run++;
    if ({m0_valid, m0_color, m0_tag} !== {1'b1, 32'h0000_0000, 8'h3C}) begin
      failures++;
      $display("FAIL all_zero: v=%b color=%h tag=%h expected 1/00000000/3c", m0_valid, m0_color, m0_tag);
    end
  endtask

  task automatic test_backpressure();
    int acc;
    drain();
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 0, 1);
      #1;
      if (s0_valid && s0_ready) acc++;
    end
    tests_run++;
    if (acc != D || s0_ready !== 1'b0) begin
      failures++;
      $display("FAIL credit_limit: accepted=%0d s0_ready=%b expected %0d/0", acc, s0_ready, D);
    end
    acc = 0;
    for (int i = 0; i < 16; i++) begin
      step(1, 0, 1, 1);
      #1;
      if (s0_valid && s0_ready) acc++;
    end
    tests_run++;
    if (acc != 15) begin
      failures++;
      $display("FAIL refill_rate: accepted=%0d expected 15", acc);
    end
  endtask

  task automatic test_alternate();
    bit ok;
    drain();
    ghist.delete();
    repeat (12) step(1, 1, 1, 1);
    ok = (ghist.size() == 11);
    for (int i = 1; i < ghist.size(); i++) if (ghist[i] == ghist[i-1]) ok = 0;
    tests_run++;
    if (!ok) begin
      failures++;
      $display("FAIL alternation: %0d grants, alternating=%0b expected 11 alternating", ghist.size(), ok);
    end
  endtask

  task automatic test_starvation();
    int n1, n0;
    drain();
    repeat (12) step(1, 1, 0, 1);
    ghist.delete();
    repeat (8) step(1, 1, 0, 1);
    n1 = 0;
    foreach (ghist[i]) if (ghist[i] == 1) n1++;
    tests_run++;
    if (n1 != 8 || ghist.size() != 8) begin
      failures++;
      $display("FAIL s1_unblocked: s1 grants=%0d of %0d expected 8 of 8", n1, ghist.size());
    end
    ghist.delete();
    repeat (8) step(1, 1, 1, 1);
    n0 = 0;
    foreach (ghist[i]) if (ghist[i] == 0) n0++;
    tests_run++;
    if (n0 < 3) begin
      failures++;
      $display("FAIL s0_starved: s0 grants=%0d expected at least 3", n0);
    end
  endtask

  task automatic test_random();
    drain();
    repeat (400) step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                     $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0);
    drain();
    tests_run++;
    if (busy !== 1'b0 || expq0.size() != 0 || expq1.size() != 0) begin
      failures++;
      $display("FAIL random_drain: busy=%b left0=%0d left1=%0d expected 0/0/0", busy, expq0.size(), expq1.size());
    end
  endtask

  task automatic test_reset_mid();
    drain();
    @(posedge aclk);
    #1;
    s0_color_a = rnd_px(); s0_color_b = rnd_px(); s0_color_c = rnd_px(); s0_color_d = rnd_px();
    s0_tag = 8'hA5; s0_valid = 1'b1; m0_ready = 1'b1;
    @(posedge aclk);
    #1;
    reset = 1'b1;
    #1;
    tests_run++;
    if ({s0_ready, s1_ready, m0_valid, m1_valid, busy} !== 5'b0 ||
        {m0_color, m0_tag, m1_color, m1_tag} !== '0) begin
      failures++;
      $display("FAIL mid_reset_outputs: s0r,s1r,m0v,m1v,busy=%b m0=%h/%h expected all zero",
               {s0_ready, s1_ready, m0_valid, m1_valid, busy}, m0_color, m0_tag);
    end
    repeat (2) @(posedge aclk);
    #1;
    s0_valid = 1'b0;
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 1, 1);
      tests_run++;
      if ({m0_valid, m1_valid, busy} !== 3'b000) begin
        failures++;
        $display("FAIL mid_reset_flush: m0v,m1v,busy=%b expected 000 at cycle %0d", {m0_valid, m1_valid, busy}, i);
      end
    end
    step(1, 1, 1, 1);
    #1;
    tests_run++;
    if ({s0_ready, s1_ready} !== 2'b10) begin
      failures++;
      $display("FAIL rr_after_reset: s0r,s1r=%b expected 10", {s0_ready, s1_ready});
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_single();
    test_saturation();
    test_backpressure();
    test_alternate();
    test_starvation();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/color_mixer_arbiter.md
Name: color_mixer_arbiter

Overview:
Shares one color mixer datapath between two requesters. Typical requesters are the texture-environment stage and the framebuffer-blend stage.
Each requester issues colorA..colorD operands over a valid/ready handshake and receives mixedColor results in order on its own result stream.
Round-robin arbitration issues at most one operation per cycle into the 2-cycle, non-stallable mixer pipeline.
Per-requester result FIFOs plus credit accounting guarantee that no result is ever dropped under back-pressure.

Parameters:
SUB_PIXEL_WIDTH, 8, bits per colour channel
NUMBER_OF_SUB_PIXEL, 4, channels per pixel (fixed 4; PIXEL_WIDTH = SUB_PIXEL_WIDTH*4)
TAG_WIDTH, 8, opaque sideband carried with each operation
FIFO_DEPTH, 4, result FIFO entries per requester (power of two, >= 2)

Ports:
aclk  input  1  clock
reset  input  1  asynchronous, active-high reset
s0_valid, s1_valid  input  1  requester i offers an operation
s0_ready, s1_ready  output  1  requester i operation accepted this cycle
s0_color_a..s0_color_d, s1_color_a..s1_color_d  input  PIXEL_WIDTH  operands of requester i
s0_tag, s1_tag  input  TAG_WIDTH  sideband of requester i
m0_valid, m1_valid  output  1  result available for requester i
m0_ready, m1_ready  input  1  requester i consumes the result
m0_color, m1_color  output  PIXEL_WIDTH  mixed result for requester i
m0_tag, m1_tag  output  TAG_WIDTH  tag returned with the result
busy  output  1  any operation in flight or any FIFO non-empty

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - clears the pipeline valid bits, in-flight counters, FIFO pointers and counts;
  - sets the RR pointer to requester 0;
  - forces s*_ready=0, m*_valid=0, m*_color=0, m*_tag=0, busy=0.
  - An assertion mid-operation discards all in-flight and buffered results; nothing emerges after release.
- Per channel k, the result is sat((a_k*b_k + c_k*d_k + (2^W-1)) >> W), with W=SUB_PIXEL_WIDTH.
  - Products are 2W bits; the sum is 2W+1 bits.
  - sat() clamps to 2^W-1.
- Credit for requester i: credit_i = FIFO_DEPTH - count_i - inflight_i.
  - Requester i is eligible when si_valid=1 and credit_i>0.
- Arbitration (combinational, same cycle):
  - Exactly one eligible requester is granted.
  - If both are eligible, the RR pointer requester wins and the pointer moves to the other requester.
  - A single eligible requester is granted and the pointer moves to the other requester.
  - With no grant, the pointer holds.
- si_ready = grant_i, combinational from si_valid and state. Transfer occurs on si_valid & si_ready.
  - An operation must hold stable while valid=1 and ready=0.
- Pipeline:
  - Stage 1 registers the eight products, the requester id and the tag.
  - Stage 2 forms the saturated sum and writes it to FIFO[id].
  - Fixed latency: issue in cycle N, write into the FIFO at the end of N+2, mi_valid=1 from N+3 at the earliest.
- inflight_i increments on issue and decrements on the FIFO write; both in the same cycle leave it unchanged.
- FIFOs:
  - mi_valid = !empty_i; mi_color/mi_tag present the head entry.
  - Pop occurs on mi_valid & mi_ready.
  - Simultaneous push and pop on a full FIFO is legal because credit already reserved the push slot.
  - Pointers wrap modulo FIFO_DEPTH.
  - A push to a full FIFO cannot occur; the bench asserts this.
- Ordering: results per requester return in issue order. There is no ordering guarantee across requesters.
- Throughput: 1 operation/cycle aggregate. A single requester with m ready held high sustains 1 operation/cycle once the pipeline has filled.
- busy = |inflight | |count, registered-state based.

Test Plan:
- s0 single op, A=0xFFFFFFFF, B=0x80808080, C=D=0 → s0_ready=1 same cycle; m0_valid 3 cycles later; m0_color=0x80808080; tag echoed.
- All operands 0xFFFFFFFF → m0_color=0xFFFFFFFF (saturation, raw 509). All zero → 0x00000000.
- m0_ready=0 with s0_valid held → exactly 4 ops accepted, then s0_ready=0. m0_ready=1 → one new accept per pop; no loss; tags in order.
- s0 and s1 both valid continuously, m*_ready=1 → grants alternate 0,1,0,1. Per-port results match and are in order.
- s0 blocked by a full FIFO while s1 is valid → s1 granted every cycle. No starvation once FIFO0 drains.
- Reset asserted one cycle after issue → all outputs 0 immediately; after release m*_valid stays 0, busy=0, RR pointer=0.
